chan_scan_mux: RTL and testbench

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

---
 rtl/chan_scan_mux_if.sv | 28 ++
 rtl/chan_scan_mux.sv | 156 +++++++++++++++
 tb/tb_chan_scan_mux.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/chan_scan_mux_if.sv
// Channel-scan mux bus: control, packed channel data and registered selection outputs.
// CHAN_SCAN_MASK_EN adds a per-channel enable mask input.
interface chan_scan_mux_if #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 7
);
  localparam int unsigned SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      run;
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic [CHANNELS*WIDTH-1:0] din;
`ifdef CHAN_SCAN_MASK_EN
  logic [CHANNELS-1:0]       mask;
`endif
  logic [WIDTH-1:0]          dout;
  logic [SELW-1:0]           ch;
  logic                      valid;
  logic                      wrap;

`ifdef CHAN_SCAN_MASK_EN
  modport master (output run, mode, sel, din, mask, input dout, ch, valid, wrap);
  modport slave  (input run, mode, sel, din, mask, output dout, ch, valid, wrap);
`else
  modport master (output run, mode, sel, din, input dout, ch, valid, wrap);
  modport slave  (input run, mode, sel, din, output dout, ch, valid, wrap);
`endif
endinterface

// File: rtl/chan_scan_mux.sv
// Channel multiplexer with manual select and timed auto-scan over enabled channels.
// Optional macro CHAN_SCAN_MASK_EN enables per-channel masking via bus.mask.
module chan_scan_mux #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 7,
  parameter int unsigned DWELL    = 4
) (
  input logic           clk,
  input logic           resetn,
  chan_scan_mux_if.slave bus
);
  localparam int unsigned SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MANUAL = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  logic [1:0]       state_q, nxt_state;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0] en_c;
  logic [SELW-1:0]  first_c, next_c;

`ifdef CHAN_SCAN_MASK_EN
  assign en_c = bus.mask;
`else
  assign en_c = '1;
`endif

  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                            input logic [SELW-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < CHANNELS; k++)
      if (32'(idx) == k) r = d[k*WIDTH +: WIDTH];
    return r;
  endfunction

  // Out-of-range indices read as disabled.
  function automatic logic chan_en(input logic [CHANNELS-1:0] en,
                                   input logic [SELW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++)
      if (32'(idx) == k) r = en[k];
    return r;
  endfunction

  // Lowest enabled channel above idx, else lowest enabled channel overall.
  function automatic logic [SELW-1:0] next_en(input logic [CHANNELS-1:0] en,
                                              input logic [SELW-1:0] idx);
    logic [SELW-1:0] lo, hi;
    logic            hi_v;
    lo   = '0;
    hi   = '0;
    hi_v = 1'b0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (en[k]) begin
        lo = SELW'(k);
        if (k > int'(idx)) begin
          hi   = SELW'(k);
          hi_v = 1'b1;
        end
      end
    end
    return hi_v ? hi : lo;
  endfunction

  function automatic logic [SELW-1:0] first_en(input logic [CHANNELS-1:0] en);
    logic [SELW-1:0] r;
    r = '0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--)
      if (en[k]) r = SELW'(k);
    return r;
  endfunction

  assign first_c = first_en(en_c);
  assign next_c  = next_en(en_c, ch_q);

  // Next state and next registered outputs.
  always_comb begin
    nxt_state = IDLE;
    dout_d    = dout_q;
    ch_d      = ch_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    cnt_d     = cnt_q;
    if (bus.run) nxt_state = bus.mode ? SCAN : MANUAL;

    case (nxt_state)
      MANUAL: begin
        ch_d  = bus.sel;
        cnt_d = '0;
        if (chan_en(en_c, bus.sel)) begin
          dout_d  = pick(bus.din, bus.sel);
          valid_d = 1'b1;
        end else begin
          dout_d  = '0;
        end
      end
      SCAN: begin
        if (en_c == '0) begin
          // Nothing to scan: park on a legal channel with no data.
          dout_d = '0;
          if (state_q != SCAN) begin
            ch_d  = '0;
            cnt_d = '0;
          end
        end else if (state_q != SCAN) begin
          ch_d    = first_c;
          cnt_d   = '0;
          valid_d = 1'b1;
          dout_d  = pick(bus.din, first_c);
        end else begin
          valid_d = 1'b1;
          if (cnt_q == CNTW'(DWELL - 1)) begin
            cnt_d  = '0;
            ch_d   = next_c;
            wrap_d = (next_c <= ch_q);
          end else begin
            cnt_d  = cnt_q + CNTW'(1);
          end
          dout_d = pick(bus.din, ch_d);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= nxt_state;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: expected outputs queued per step, checked after the edge.
module tb_chan_scan_mux;
  localparam int unsigned WIDTH    = 1;
  localparam int unsigned CHANNELS = 7;
  localparam int unsigned DWELL    = 4;
  localparam int unsigned SELW     = 3;

  typedef struct packed {
    logic            dout;
    logic [SELW-1:0] ch;
    logic            valid;
    logic            wrap;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  chan_scan_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  chan_scan_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic d, input logic [SELW-1:0] c,
                              input logic v, input logic w);
    exp_t e;
    e.dout  = d;
    e.ch    = c;
    e.valid = v;
    e.wrap  = w;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input logic rn, input logic r, input logic m,
                      input logic [SELW-1:0] s, input logic [6:0] d,
                      input exp_t e, input string tag);
    exp_t got;
    resetn   = rn;
    bus.run  = r;
    bus.mode = m;
    bus.sel  = s;
    bus.din  = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".dout"},  32'(bus.dout),  32'(got.dout));
    chk({tag, ".ch"},    32'(bus.ch),    32'(got.ch));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(got.valid));
    chk({tag, ".wrap"},  32'(bus.wrap),  32'(got.wrap));
  endtask

  initial begin
    logic [6:0]      da, db, d;
    logic [SELW-1:0] c;
    logic            last_dout;
    int              i;
    da = 7'b1011001;
    db = 7'b0100110;
    resetn   = 1'b0;
    bus.run  = 1'b1;
    bus.mode = 1'b0;
    bus.sel  = '0;
    bus.din  = '0;
`ifdef CHAN_SCAN_MASK_EN
    bus.mask = '1;
`endif

    // Reset held two cycles with run high
    step(0, 1, 1, 3'd0, 7'h7f, mk(0, 0, 0, 0), "rst0");
    step(0, 1, 1, 3'd0, 7'h7f, mk(0, 0, 0, 0), "rst1");

    // Manual selection, legal and illegal indices
    step(1, 1, 0, 3'd5, 7'b0100000, mk(1, 5, 1, 0), "man5");
    step(1, 1, 0, 3'd7, 7'b0100000, mk(0, 7, 0, 0), "man7");
    step(1, 1, 0, 3'd4, 7'b0100000, mk(0, 4, 1, 0), "man4");
    step(1, 1, 0, 3'd6, 7'b1000000, mk(1, 6, 1, 0), "man6");
    step(1, 1, 0, 3'd0, 7'b1111110, mk(0, 0, 1, 0), "man0");
    step(1, 1, 0, 3'd5, 7'b0100000, mk(1, 5, 1, 0), "man5b");

    // Idle holds dout/ch, drops valid
    step(1, 0, 0, 3'd2, 7'b0000000, mk(1, 5, 0, 0), "idle");

    // Full scan with live data change halfway
    for (i = 0; i < 30; i++) begin
      c = 3'((i / 4) % 7);
      d = (i < 15) ? da : db;
      step(1, 1, 1, 3'd0, d, mk(d[c], c, 1, i == 28), $sformatf("scan%0d", i));
    end
    last_dout = db[0];
    step(1, 0, 1, 3'd0, da, mk(last_dout, 0, 0, 0), "idle2");

    // Rescan to ch=3 count 2, then drop to manual sel=1
    for (i = 0; i < 15; i++) begin
      c = 3'((i / 4) % 7);
      step(1, 1, 1, 3'd0, da, mk(da[c], c, 1, 0), $sformatf("pre%0d", i));
    end
    step(1, 1, 0, 3'd1, da, mk(da[1], 1, 1, 0), "midman");

    // Back to scan restarts at ch=0, count 0; run on to ch=4
    for (i = 0; i < 17; i++) begin
      c = 3'((i / 4) % 7);
      step(1, 1, 1, 3'd1, db, mk(db[c], c, 1, 0), $sformatf("rescan%0d", i));
    end

    // Reset mid-scan, then release into scan
    step(0, 1, 1, 3'd0, db, mk(0, 0, 0, 0), "rstmid");
    for (i = 0; i < 6; i++) begin
      c = 3'((i / 4) % 7);
      step(1, 1, 1, 3'd0, da, mk(da[c], c, 1, 0), $sformatf("post%0d", i));
    end

`ifdef CHAN_SCAN_MASK_EN
    begin
      logic [SELW-1:0] mseq [3];
      mseq = '{3'd1, 3'd4, 3'd6};
      bus.mask = 7'b1010010;
      step(1, 0, 1, 3'd0, da, mk(da[1], 1, 0, 0), "midle");
      step(1, 1, 0, 3'd2, da, mk(0, 2, 0, 0), "mman2");
      for (i = 0; i < 14; i++) begin
        c = mseq[(i / 4) % 3];
        step(1, 1, 1, 3'd0, da, mk(da[c], c, 1, i == 12), $sformatf("mscan%0d", i));
      end
      bus.mask = '0;
      step(1, 1, 1, 3'd0, da, mk(0, 1, 0, 0), "mzero");
      step(1, 1, 1, 3'd0, da, mk(0, 1, 0, 0), "mzero2");
      bus.mask = '1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
